// File: rtl/tlc_sensor_if_if.sv
// Detector/lamp bundle between the loop front end and the light controller.
// slave is the front end's view; master is the controller/bench view.
interface tlc_sensor_if_if;
  logic HLOOP_RAW;
  logic FLOOP_RAW;
  logic HLEFT;
  logic FLEFT;
  logic HS;
  logic FS;
  logic HDET;
  logic FDET;
  logic HSTUCK;
  logic FSTUCK;

  modport slave (
    input  HLOOP_RAW, FLOOP_RAW, HLEFT, FLEFT,
    output HS, FS, HDET, FDET, HSTUCK, FSTUCK
  );

  modport master (
    output HLOOP_RAW, FLOOP_RAW, HLEFT, FLEFT,
    input  HS, FS, HDET, FDET, HSTUCK, FSTUCK
  );
endinterface

// File: rtl/tlc_sensor_if.sv
// Loop-detector front end: sync, debounce, stuck-on watch and a request
// latch per channel that holds until the left-turn lamp shows service.
module tlc_sensor_chan #(
  parameter int DEB_CYCLES   = 4,
  parameter int DEB_W        = 3,
  parameter int STUCK_CYCLES = 255,
  parameter int STUCK_W      = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  input  logic i_lamp,
  output logic o_req,
  output logic o_det,
  output logic o_stuck
);
  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    SERVING
  } state_t;

  localparam logic [DEB_W-1:0]   DEB_MAX = DEB_W'(DEB_CYCLES - 1);
  localparam logic [STUCK_W-1:0] STK_MAX = STUCK_W'(STUCK_CYCLES);

  state_t r_state;
  state_t w_next;
  logic r_sync1;
  logic r_sync2;
  logic r_det;
  logic r_stuck;
  logic [DEB_W-1:0]   r_deb;
  logic [STUCK_W-1:0] r_stk;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_det   <= 1'b0;
      r_deb   <= '0;
      r_stk   <= '0;
      r_stuck <= 1'b0;
      r_state <= IDLE;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_state <= w_next;
      if (r_sync2 == r_det) begin
        r_deb <= '0;
      end else if (r_deb == DEB_MAX) begin
        r_det <= r_sync2;
        r_deb <= '0;
      end else begin
        r_deb <= r_deb + 1'b1;
      end
      // Flag raises together with the counter hitting its limit.
      if (!r_det) begin
        r_stk   <= '0;
        r_stuck <= 1'b0;
      end else if (r_stk != STK_MAX) begin
        r_stk <= r_stk + 1'b1;
        if (r_stk == STK_MAX - 1'b1)
          r_stuck <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (r_det)
          w_next = i_lamp ? SERVING : PENDING;
      end
      PENDING: begin
        if (i_lamp)
          w_next = SERVING;
      end
      SERVING: begin
        if (!i_lamp)
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign o_req   = (r_state == PENDING) && !r_stuck;
  assign o_det   = r_det;
  assign o_stuck = r_stuck;
endmodule

module tlc_sensor_if #(
  parameter int DEB_CYCLES   = 4,
  parameter int DEB_W        = 3,
  parameter int STUCK_CYCLES = 255,
  parameter int STUCK_W      = 8
) (
  input  logic CLOCK,
  input  logic RESET,
  tlc_sensor_if_if.slave bus
);
  tlc_sensor_chan #(
    .DEB_CYCLES  (DEB_CYCLES),
    .DEB_W       (DEB_W),
    .STUCK_CYCLES(STUCK_CYCLES),
    .STUCK_W     (STUCK_W)
  ) u_h (
    .i_clk  (CLOCK),
    .i_rst  (RESET),
    .i_raw  (bus.HLOOP_RAW),
    .i_lamp (bus.HLEFT),
    .o_req  (bus.HS),
    .o_det  (bus.HDET),
    .o_stuck(bus.HSTUCK)
  );

  tlc_sensor_chan #(
    .DEB_CYCLES  (DEB_CYCLES),
    .DEB_W       (DEB_W),
    .STUCK_CYCLES(STUCK_CYCLES),
    .STUCK_W     (STUCK_W)
  ) u_f (
    .i_clk  (CLOCK),
    .i_rst  (RESET),
    .i_raw  (bus.FLOOP_RAW),
    .i_lamp (bus.FLEFT),
    .o_req  (bus.FS),
    .o_det  (bus.FDET),
    .o_stuck(bus.FSTUCK)
  );
endmodule

// File: tb/tb_tlc_sensor_if.sv
// Bench for tlc_sensor_if: default instance plus a short-stuck instance,
// both checked every cycle against a behavioural model.
module tb_tlc_sensor_if;
  localparam int DEB = 4;

  logic clk;
  logic rst;
  logic hraw, fraw, hlft, flft;
  logic p_rst;
  logic p_raw [2];
  logic p_lmp [2];
  int   n_cmp;
  int   n_bad;

  tlc_sensor_if_if if0 ();
  tlc_sensor_if_if if1 ();

  assign if0.HLOOP_RAW = hraw;
  assign if0.FLOOP_RAW = fraw;
  assign if0.HLEFT     = hlft;
  assign if0.FLEFT     = flft;
  assign if1.HLOOP_RAW = hraw;
  assign if1.FLOOP_RAW = fraw;
  assign if1.HLEFT     = hlft;
  assign if1.FLEFT     = flft;

  tlc_sensor_if u0 (
    .CLOCK(clk),
    .RESET(rst),
    .bus  (if0.slave)
  );

  tlc_sensor_if #(
    .STUCK_CYCLES(16),
    .STUCK_W     (5)
  ) u1 (
    .CLOCK(clk),
    .RESET(rst),
    .bus  (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    p_rst    <= rst;
    p_raw[0] <= hraw;
    p_raw[1] <= fraw;
    p_lmp[0] <= hlft;
    p_lmp[1] <= flft;
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkv(input logic [11:0] act, input logic [11:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL outs: got %h expected %h at %0t", act, exp, $time);
    end
  endtask

  // Model: k = dut*2 + chan (chan 0 = H, 1 = F); st 0 idle, 1 pending, 2 serving
  int  m_s1 [4];
  int  m_s2 [4];
  int  m_det [4];
  int  m_run [4];
  int  m_stk [4];
  int  m_st [4];
  bit  m_hist [4][$];
  bit  m_valid;

  initial begin
    int c, lim, od, os;
    bit flip;
    logic [11:0] act, exp;
    m_valid = 1'b0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        c   = k % 2;
        lim = (k < 2) ? 255 : 16;
        if (p_rst) begin
          m_s1[k] = 0; m_s2[k] = 0; m_det[k] = 0;
          m_run[k] = 0; m_stk[k] = 0; m_st[k] = 0;
          m_hist[k].delete();
        end else begin
          od = m_det[k];
          os = m_st[k];
          // level flips once the last DEB synced samples all disagree
          m_hist[k].push_back(m_s2[k] != 0);
          if (m_hist[k].size() > DEB) void'(m_hist[k].pop_front());
          flip = (m_hist[k].size() == DEB);
          foreach (m_hist[k][i])
            if (int'(m_hist[k][i]) == od) flip = 1'b0;
          if (flip) begin
            m_det[k] = 1 - od;
            m_hist[k].delete();
          end
          m_run[k] = od ? ((m_run[k] < lim) ? m_run[k] + 1 : lim) : 0;
          m_stk[k] = (od != 0 && m_run[k] >= lim) ? 1 : 0;
          if (os == 0 && od != 0)
            m_st[k] = p_lmp[c] ? 2 : 1;
          else if (os == 1 && p_lmp[c])
            m_st[k] = 2;
          else if (os == 2 && !p_lmp[c])
            m_st[k] = 0;
          m_s2[k] = m_s1[k];
          m_s1[k] = int'(p_raw[c]);
          if (k == 3) m_valid = 1'b1;
        end
      end
      if (p_rst) m_valid = 1'b1;
      if (m_valid) begin
        for (int k = 0; k < 4; k++)
          exp[k*3 +: 3] = {m_st[k] == 1 && m_stk[k] == 0,
                           m_det[k] != 0, m_stk[k] != 0};
        act[0 +: 3] = {if0.HS, if0.HDET, if0.HSTUCK};
        act[3 +: 3] = {if0.FS, if0.FDET, if0.FSTUCK};
        act[6 +: 3] = {if1.HS, if1.HDET, if1.HSTUCK};
        act[9 +: 3] = {if1.FS, if1.FDET, if1.FSTUCK};
        chkv(act, exp);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    hraw = 1'b0; fraw = 1'b0; hlft = 1'b0; flft = 1'b0;
    tick(2);
    rst = 1'b0;
    chk1("rst_hs", if0.HS, 1'b0);
    chk1("rst_hdet", if0.HDET, 1'b0);
    chk1("rst_fs", if1.FS, 1'b0);
    // highway detect latency
    hraw = 1'b1;
    tick(5);
    chk1("s1_hdet_e5", if0.HDET, 1'b0);
    tick(1);
    chk1("s1_hdet_e6", if0.HDET, 1'b1);
    chk1("s1_hs_e6", if0.HS, 1'b0);
    tick(1);
    chk1("s1_hs_e7", if0.HS, 1'b1);
    chk1("s1_fs", if0.FS, 1'b0);
    chk1("s1_fdet", if0.FDET, 1'b0);
    // lamp pulse with detector held
    hlft = 1'b1;
    tick(1);
    chk1("s5_hs_drop", if0.HS, 1'b0);
    tick(4);
    hlft = 1'b0;
    tick(1);
    chk1("s5_hs_idle", if0.HS, 1'b0);
    tick(1);
    chk1("s5_hs_again", if0.HS, 1'b1);
    // latched request across detector drop
    hraw = 1'b0;
    tick(10);
    chk1("s3_hs_hold", if0.HS, 1'b1);
    chk1("s3_hdet_low", if0.HDET, 1'b0);
    hlft = 1'b1;
    tick(1);
    chk1("s3_hs_drop", if0.HS, 1'b0);
    hlft = 1'b0;
    tick(3);
    chk1("s3_hs_stay", if0.HS, 1'b0);
    // short farm glitch
    fraw = 1'b1;
    tick(3);
    fraw = 1'b0;
    tick(10);
    chk1("s2_fdet", if0.FDET, 1'b0);
    chk1("s2_fs", if0.FS, 1'b0);
    // farm stuck on the 16-cycle instance
    fraw = 1'b1;
    tick(21);
    chk1("s4_fs_pre", if1.FS, 1'b1);
    chk1("s4_stk_pre", if1.FSTUCK, 1'b0);
    tick(1);
    chk1("s4_stk_set", if1.FSTUCK, 1'b1);
    chk1("s4_fs_mask", if1.FS, 1'b0);
    chk1("s4_def_fs", if0.FS, 1'b1);
    chk1("s4_def_stk", if0.FSTUCK, 1'b0);
    fraw = 1'b0;
    tick(6);
    chk1("s4_fdet_low", if1.FDET, 1'b0);
    chk1("s4_stk_hold", if1.FSTUCK, 1'b1);
    tick(1);
    chk1("s4_stk_clr", if1.FSTUCK, 1'b0);
    chk1("s4_fs_back", if1.FS, 1'b1);
    flft = 1'b1;
    tick(2);
    flft = 1'b0;
    tick(2);
    // reset while pending
    hraw = 1'b1;
    tick(7);
    chk1("s6_hs_pend", if0.HS, 1'b1);
    rst = 1'b1;
    tick(1);
    chk1("s6_hs_rst", if0.HS, 1'b0);
    chk1("s6_hdet_rst", if0.HDET, 1'b0);
    rst = 1'b0;
    tick(6);
    chk1("s6_hs_e6", if0.HS, 1'b0);
    tick(1);
    chk1("s6_hs_e7", if0.HS, 1'b1);
    // random bouncing inputs and lamps
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(5) == 0) hraw = ~hraw;
      if ($urandom_range(5) == 0) fraw = ~fraw;
      if ($urandom_range(9) == 0) hlft = ~hlft;
      if ($urandom_range(9) == 0) flft = ~flft;
      rst = ($urandom_range(499) == 0);
      tick(1);
    end
    // long hold to trip the default stuck limit
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    hraw = 1'b1; hlft = 1'b0; fraw = 1'b0; flft = 1'b0;
    tick(300);
    chk1("lh_hstuck", if0.HSTUCK, 1'b1);
    chk1("lh_hs", if0.HS, 1'b0);
    chk1("lh_hdet", if0.HDET, 1'b1);
    hraw = 1'b0;
    tick(7);
    chk1("lh_hstuck_clr", if0.HSTUCK, 1'b0);
    chk1("lh_hs_back", if0.HS, 1'b1);
    tick(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
